// File: rtl/vending_pkg.sv
// Shared types and helpers for the multi-item vending machine.
// Holds the controller state encoding and the accepted coin denominations.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  localparam int unsigned COIN_1   = 1;
  localparam int unsigned COIN_2   = 2;
  localparam int unsigned COIN_5   = 5;
  localparam int unsigned COIN_10  = 10;
  localparam int unsigned COIN_20  = 20;
  localparam int unsigned COIN_50  = 50;
  localparam int unsigned COIN_100 = 100;

  function automatic logic coin_is_valid(input int unsigned value);
    return (value == COIN_1)  || (value == COIN_2)  || (value == COIN_5)  ||
           (value == COIN_10) || (value == COIN_20) || (value == COIN_50) ||
           (value == COIN_100);
  endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-item stock counters: restock, masked decrement, empty flags and a
// sold-out check of a selection mask.
module vm_stock_bank #(
  parameter int unsigned NUM_ITEMS  = 5,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned INIT_STOCK = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restock_i,
  input  logic [NUM_ITEMS-1:0] dec_i,
  input  logic [NUM_ITEMS-1:0] check_i,
  output logic [NUM_ITEMS-1:0] empty_c,
  output logic                 sold_out_c
);

  logic [STOCK_W-1:0] r_stock [NUM_ITEMS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_ITEMS); i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      for (int i = 0; i < int'(NUM_ITEMS); i++) begin
        if (restock_i)     r_stock[i] <= STOCK_W'(INIT_STOCK);
        else if (dec_i[i]) r_stock[i] <= r_stock[i] - STOCK_W'(1);
      end
    end
  end

  always_comb begin
    empty_c = '0;
    for (int i = 0; i < int'(NUM_ITEMS); i++) empty_c[i] = (r_stock[i] == '0);
  end

  assign sold_out_c = |(check_i & empty_c);

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: coin credit, all-or-nothing multi-item vend,
// per-item stock, cancel/timeout refund and a held change handshake.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = 5,
  parameter int unsigned MONEY_W   = 9,
  parameter logic [NUM_ITEMS*MONEY_W-1:0] PRICES = {9'd30, 9'd100, 9'd10, 9'd40, 9'd20},
  parameter int unsigned MAX_CREDIT  = 500,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned INIT_STOCK  = 3,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coin_valid_i,
  input  logic [MONEY_W-1:0]   coin_value_i,
  input  logic                 select_valid_i,
  input  logic [NUM_ITEMS-1:0] select_i,
  input  logic                 cancel_i,
  input  logic                 change_ack_i,
  input  logic                 restock_i,
  output logic                 vend_valid_o,
  output logic [NUM_ITEMS-1:0] vend_o,
  output logic                 change_valid_o,
  output logic [MONEY_W-1:0]   change_o,
  output logic [MONEY_W-1:0]   credit_o,
  output logic                 insufficient_money_o,
  output logic                 money_invalid_o,
  output logic                 sold_out_o,
  output logic [NUM_ITEMS-1:0] empty_o
);

  localparam int unsigned SUM_W = MONEY_W + $clog2(NUM_ITEMS);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  state_t               r_state;
  logic [MONEY_W-1:0]   r_credit;
  logic [NUM_ITEMS-1:0] r_mask;
  logic [SUM_W-1:0]     r_total;
  logic [TMR_W-1:0]     r_timer;

  logic [SUM_W-1:0]     w_total;
  logic [MONEY_W:0]     w_coin_sum;
  logic                 w_coin_ok;
  logic [MONEY_W-1:0]   w_vend_change;
  logic                 w_sold_out;
  logic [NUM_ITEMS-1:0] w_empty;
  logic [NUM_ITEMS-1:0] w_dec;
  logic                 w_restock;

  // Price of the requested basket, wide enough that no selection overflows.
  always_comb begin
    w_total = '0;
    for (int i = 0; i < int'(NUM_ITEMS); i++)
      if (select_i[i]) w_total = w_total + SUM_W'(PRICES[i*MONEY_W +: MONEY_W]);
  end

  assign w_coin_sum    = (MONEY_W+1)'(r_credit) + (MONEY_W+1)'(coin_value_i);
  assign w_coin_ok     = coin_is_valid(32'(coin_value_i)) &&
                         (w_coin_sum <= (MONEY_W+1)'(MAX_CREDIT));
  assign w_vend_change = r_credit - MONEY_W'(r_total);
  assign w_dec         = (r_state == ST_VEND) ? r_mask : '0;
  assign w_restock     = restock_i && (r_state == ST_IDLE);

  vm_stock_bank #(
    .NUM_ITEMS (NUM_ITEMS),
    .STOCK_W   (STOCK_W),
    .INIT_STOCK(INIT_STOCK)
  ) u_stock (
    .clk       (clk),
    .rst       (rst),
    .restock_i (w_restock),
    .dec_i     (w_dec),
    .check_i   (select_i),
    .empty_c   (w_empty),
    .sold_out_c(w_sold_out)
  );

  assign empty_o  = w_empty;
  assign credit_o = r_credit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state              <= ST_IDLE;
      r_credit             <= '0;
      r_mask               <= '0;
      r_total              <= '0;
      r_timer              <= '0;
      vend_valid_o         <= 1'b0;
      vend_o               <= '0;
      change_valid_o       <= 1'b0;
      change_o             <= '0;
      insufficient_money_o <= 1'b0;
      money_invalid_o      <= 1'b0;
      sold_out_o           <= 1'b0;
    end else begin
      vend_valid_o         <= 1'b0;
      vend_o               <= '0;
      insufficient_money_o <= 1'b0;
      money_invalid_o      <= 1'b0;
      sold_out_o           <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (coin_valid_i) begin
            if (w_coin_ok) begin
              r_credit <= w_coin_sum[MONEY_W-1:0];
              r_state  <= ST_CREDIT;
            end else begin
              money_invalid_o <= 1'b1;
            end
          end
        end
        ST_CREDIT: begin
          // cancel beats select beats coin; a losing coin is bounced
          if (cancel_i) begin
            r_timer         <= '0;
            change_o        <= r_credit;
            change_valid_o  <= 1'b1;
            r_credit        <= '0;
            r_state         <= ST_CHANGE;
            money_invalid_o <= coin_valid_i;
          end else if (select_valid_i) begin
            r_timer         <= '0;
            money_invalid_o <= coin_valid_i;
            if (select_i != '0) begin
              if (w_sold_out) begin
                sold_out_o <= 1'b1;
              end else if (w_total > SUM_W'(r_credit)) begin
                insufficient_money_o <= 1'b1;
              end else begin
                r_mask  <= select_i;
                r_total <= w_total;
                r_state <= ST_VEND;
              end
            end
          end else if (coin_valid_i) begin
            r_timer <= '0;
            if (w_coin_ok) r_credit <= w_coin_sum[MONEY_W-1:0];
            else           money_invalid_o <= 1'b1;
          end else if (r_timer == TMR_W'(TIMEOUT_CYC - 1)) begin
            r_timer        <= '0;
            change_o       <= r_credit;
            change_valid_o <= 1'b1;
            r_credit       <= '0;
            r_state        <= ST_CHANGE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_VEND: begin
          money_invalid_o <= coin_valid_i;
          vend_valid_o    <= 1'b1;
          vend_o          <= r_mask;
          r_credit        <= '0;
          if (w_vend_change != '0) begin
            change_o       <= w_vend_change;
            change_valid_o <= 1'b1;
            r_state        <= ST_CHANGE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CHANGE: begin
          money_invalid_o <= coin_valid_i;
          if (change_ack_i) begin
            change_valid_o <= 1'b0;
            change_o       <= '0;
            r_state        <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
